pac_sprite_ctrl: RTL and testbench
==================================

Name: pac_sprite_ctrl

Overview:
Sequences the 13x13 Pac-Man sprite ROM (7-bit row address, 13-bit row data, 9 frame codes of 13 rows each) for the VGA pixel pipeline.
- Runs the mouth-animation state machine, advanced once per video frame.
- Latches direction at frame boundaries.
- Converts the current scan position into ROM row addresses.
- Emits a registered per-pixel "Pac-Man opaque" flag to the colour mapper.

Parameters:
ANIM_DIV, 4, number of frames per animation step (1..15)
SPR_SIZE, 13, sprite width and height in pixels; fixed to match the ROM

Ports:
Clk  in  1  pixel clock
Reset  in  1  asynchronous, active-high reset
VGA_VS  in  1  vertical sync, active low
DrawX  in  10  current scan column
DrawY  in  10  current scan row
pac_x  in  10  sprite top-left column
pac_y  in  10  sprite top-left row
pac_dir  in  2  movement direction: 0 up, 1 right, 2 down, 3 left
pac_moving  in  1  Pac-Man is moving this frame
rom_addr  out  7  address to the sprite ROM (registered)
rom_data  in  13  ROM row data, combinational from rom_addr; bit 12 is the leftmost column
pac_pixel  out  1  current pixel is opaque Pac-Man (registered)
anim_code  out  4  current frame code 0..8 (debug and score logic)

Behaviour:
- Reset: every register clears; rom_addr=0, pac_pixel=0, anim_code=0, state CLOSED, dir_l=0, div_cnt=0, vs_d=1.
- Frame tick: a one-cycle pulse `tick` fires when vs_d=1 and VGA_VS=0 (falling edge of VGA_VS). vs_d is VGA_VS registered each cycle.
- On tick:
  - dir_l <= pac_dir.
  - If pac_moving: div_cnt increments. When div_cnt==ANIM_DIV-1, div_cnt wraps to 0 and the state advances.
  - If not pac_moving: div_cnt <= 0.
- A pac_dir change in the same cycle as tick uses the new value. Between ticks, dir_l and the state are frozen, so there is no mid-frame tearing.
- FSM (enum anim_state_t) cycles CLOSED -> HALF -> FULL -> HALF_BK -> CLOSED. Each transition happens only on a tick that wraps div_cnt.
- Frame code: CLOSED gives 0. HALF and HALF_BK give 1+2*dir_l. FULL gives 2+2*dir_l. anim_code is registered and updates the cycle after the tick.
- Hit test (stage 0), using 11-bit unsigned arithmetic so the sprite never wraps at the screen edge:
  - hit = (DrawX >= pac_x) && (DrawX < pac_x+13) && (DrawY >= pac_y) && (DrawY < pac_y+13).
  - row = DrawY-pac_y and col = DrawX-pac_x, each 4 bits and valid only when hit.
- Stage 1 (registered):
  - rom_addr <= hit ? code*13+row : 0. The 7-bit product is at most 8*13+12=116, so it cannot overflow.
  - col_q <= col and hit_q <= hit.
- Stage 2 (registered): pac_pixel <= hit_q & rom_data[12-col_q].
- Latency: DrawX/DrawY at cycle n produces pac_pixel at cycle n+2. The colour mapper delays the background path by 2 cycles to match.
- Sprites partially off-screen: only the visible pixels assert; there is no wrap to column 0.
- Reset mid-frame: outputs drop to 0 immediately. The first tick after release restarts the animation from CLOSED.

Optional Feature:
PAC_STOP_CLOSED_EN
- Defined: a tick with pac_moving=0 forces the state to CLOSED and clears div_cnt.
- Undefined: when Pac-Man stops, the state holds its current value (mouth frozen open or closed) and div_cnt clears.

Decomposition:
- pacman_pkg holds:
  - anim_state_t (CLOSED, HALF, FULL, HALF_BK)
  - dir_t constants DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT
  - SPR_SIZE=13 and SPR_ROWS_PER_CODE=13
  - function frame_code(state, dir)
- One sub-module, pac_anim_fsm: tick edge detect, div_cnt, the FSM and the code output.
- The address/pixel pipeline stays in the top level. The ROM is instantiated outside this block.

Test Plan:
1. Reset asserted mid-line with pac_moving=1 -> rom_addr=0, pac_pixel=0 and anim_code=0 in the same cycle, without waiting for a clock edge.
2. ANIM_DIV=4, pac_dir=1, pac_moving=1, 16 VS falling edges -> anim_code 0,3,4,3,0, changing after ticks 4, 8, 12 and 16, each visible one cycle after its tick.
3. pac_x=100, pac_y=50, code 0, scan DrawY=56 with DrawX 98..114 -> pac_pixel (2-cycle delay) is 1 for DrawX 100..112 and 0 at 98, 99, 113, 114; rom_addr=6 on those cycles.
4. pac_x=630 (sprite straddles the right edge), DrawX 630..639 -> pixels follow rom_data cols 0..9; DrawX=0..2 never hits.
5. pac_dir changes from 1 to 3 mid-frame while in FULL -> anim_code stays 4 until the next tick, then becomes 8 in the same cycle as the direction latch.
6. pac_moving drops while in FULL -> without the macro anim_code stays at 4 over 8 ticks; with PAC_STOP_CLOSED_EN, anim_code becomes 0 after the next tick.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types, sprite geometry and frame-code mapping for the Pac-Man sprite controller.
// Optional build macro consumed elsewhere: PAC_STOP_CLOSED_EN.
package pacman_pkg;

    localparam int unsigned SPR_SIZE          = 13;
    localparam int unsigned SPR_ROWS_PER_CODE = 13;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        HALF    = 2'd1,
        FULL    = 2'd2,
        HALF_BK = 2'd3
    } anim_state_t;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    // Each direction owns a half-open/full-open pair of codes after the shared closed code 0.
    function automatic logic [3:0] frame_code(anim_state_t s, dir_t d);
        logic [3:0] base;
        logic [3:0] code;
        base = {1'b0, d, 1'b0};
        code = '0;
        case (s)
            CLOSED:        code = '0;
            HALF, HALF_BK: code = base + 4'd1;
            FULL:          code = base + 4'd2;
            default:       code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pac_sprite_ctrl_if.sv
// Video-side bus of the sprite controller: scan position, sprite control, ROM port and pixel outputs.
interface pac_sprite_ctrl_if;
    import pacman_pkg::*;

    logic        VGA_VS;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  pac_x;
    logic [9:0]  pac_y;
    dir_t        pac_dir;
    logic        pac_moving;
    logic [6:0]  rom_addr;
    logic [12:0] rom_data;
    logic        pac_pixel;
    logic [3:0]  anim_code;

    modport slave (
        input  VGA_VS, DrawX, DrawY, pac_x, pac_y, pac_dir, pac_moving, rom_data,
        output rom_addr, pac_pixel, anim_code
    );

    modport master (
        output VGA_VS, DrawX, DrawY, pac_x, pac_y, pac_dir, pac_moving, rom_data,
        input  rom_addr, pac_pixel, anim_code
    );

endinterface

// File: rtl/pac_anim_fsm.sv
// Mouth animation: VS falling-edge tick, frame divider, CLOSED/HALF/FULL/HALF_BK cycle, code output.
// With PAC_STOP_CLOSED_EN defined, a stopped tick snaps the mouth back to CLOSED.
module pac_anim_fsm
    import pacman_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vs_i,
    input  dir_t       dir_i,
    input  logic       moving_i,
    output logic [3:0] code_o
);

    localparam logic [3:0] DIV_LAST = 4'(ANIM_DIV - 1);

    logic        vs_q;
    logic        tick;
    logic [3:0]  div_cnt_q, div_cnt_d;
    anim_state_t state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [3:0]  code_q, code_d;

    assign tick = vs_q & ~vs_i;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        div_cnt_d = div_cnt_q;
        if (tick) begin
            dir_d = dir_i;
            if (moving_i) begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    unique case (state_q)
                        CLOSED:  state_d = HALF;
                        HALF:    state_d = FULL;
                        FULL:    state_d = HALF_BK;
                        HALF_BK: state_d = CLOSED;
                    endcase
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
            end else begin
                div_cnt_d = '0;
`ifdef PAC_STOP_CLOSED_EN
                state_d = CLOSED;
`else
                state_d = state_q;
`endif
            end
        end
        // Code follows the next-state values so it is visible the cycle after the tick.
        code_d = frame_code(state_d, dir_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q      <= 1'b1;
            div_cnt_q <= '0;
            state_q   <= CLOSED;
            dir_q     <= DIR_UP;
            code_q    <= '0;
        end else begin
            vs_q      <= vs_i;
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            code_q    <= code_d;
        end
    end

    assign code_o = code_q;

endmodule

// File: rtl/pac_sprite_ctrl.sv
// Pac-Man sprite sequencer: hit test, ROM row addressing and registered opaque-pixel flag (2-cycle latency).
// Optional build macro PAC_STOP_CLOSED_EN is handled inside pac_anim_fsm.
module pac_sprite_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 4
) (
    input logic              Clk,
    input logic              Reset,
    pac_sprite_ctrl_if.slave bus
);

    logic [3:0]  code;
    logic [10:0] x_ext, y_ext, px_ext, py_ext;
    logic        hit;
    logic [3:0]  row, col;
    logic [6:0]  rom_addr_q, rom_addr_d;
    logic [3:0]  col_q, col_d;
    logic        hit_q;
    logic        pix_q, pix_d;
    logic [15:0] rom_ext;
    logic [3:0]  bit_idx;

    pac_anim_fsm #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .vs_i     (bus.VGA_VS),
        .dir_i    (bus.pac_dir),
        .moving_i (bus.pac_moving),
        .code_o   (code)
    );

    // 11-bit compare so a sprite near column 639 never wraps back to column 0.
    assign x_ext  = {1'b0, bus.DrawX};
    assign y_ext  = {1'b0, bus.DrawY};
    assign px_ext = {1'b0, bus.pac_x};
    assign py_ext = {1'b0, bus.pac_y};

    assign hit = (x_ext >= px_ext) && (x_ext < px_ext + 11'(SPR_SIZE)) &&
                 (y_ext >= py_ext) && (y_ext < py_ext + 11'(SPR_SIZE));

    assign row = 4'(bus.DrawY - bus.pac_y);
    assign col = 4'(bus.DrawX - bus.pac_x);

    always_comb begin
        rom_addr_d = '0;
        col_d      = '0;
        if (hit) begin
            rom_addr_d = ({3'b000, code} * 7'(SPR_ROWS_PER_CODE)) + {3'b000, row};
            col_d      = col;
        end
    end

    assign rom_ext = {3'b000, bus.rom_data};
    assign bit_idx = 4'(SPR_SIZE - 1) - col_q;
    assign pix_d   = hit_q & rom_ext[bit_idx];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q <= '0;
            col_q      <= '0;
            hit_q      <= 1'b0;
            pix_q      <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            col_q      <= col_d;
            hit_q      <= hit;
            pix_q      <= pix_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pac_pixel = pix_q;
    assign bus.anim_code = code;

endmodule

// File: tb/tb_pac_sprite_ctrl.sv
// Directed + randomized bench for pac_sprite_ctrl against an integer-level model of the animation and pixel rules.
module tb_pac_sprite_ctrl;
    import pacman_pkg::*;

    localparam int unsigned ANIM_DIV = 4;

    logic Clk = 1'b0;
    logic Reset;

    pac_sprite_ctrl_if bus ();

    pac_sprite_ctrl #(
        .ANIM_DIV (ANIM_DIV)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    logic [12:0] rom_mem [128];
    assign bus.rom_data = rom_mem[bus.rom_addr];

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0..3 = closed, half, full, half-back; m_cnt counts moving ticks toward the next step.
    int m_phase, m_cnt, m_dir, m_code, p1_pix;
    bit m_vs_prev;

    function automatic int code_of(int phase, int dir);
        if (phase == 0) return 0;
        if (phase == 2) return 2 + 2 * dir;
        return 1 + 2 * dir;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_dir = 0; m_code = 0; p1_pix = 0; m_vs_prev = 1'b1;
    endtask

    task automatic cycle();
        int dx, dy, exp_addr, exp_pix;
        bit hit;
        dx = int'(bus.DrawX) - int'(bus.pac_x);
        dy = int'(bus.DrawY) - int'(bus.pac_y);
        hit = (dx >= 0) && (dx < 13) && (dy >= 0) && (dy < 13);
        exp_addr = 0;
        exp_pix  = 0;
        if (hit) begin
            exp_addr = m_code * 13 + dy;
            exp_pix  = int'(rom_mem[exp_addr][12 - dx]);
        end
        if (m_vs_prev && !bus.VGA_VS) begin
            m_dir = int'(bus.pac_dir);
            if (bus.pac_moving) begin
                m_cnt++;
                if (m_cnt == ANIM_DIV) begin
                    m_cnt = 0;
                    m_phase = (m_phase + 1) % 4;
                end
            end else begin
                m_cnt = 0;
`ifdef PAC_STOP_CLOSED_EN
                m_phase = 0;
`endif
            end
            m_code = code_of(m_phase, m_dir);
        end
        m_vs_prev = bus.VGA_VS;
        @(posedge Clk);
        #1;
        check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
        check("pac_pixel", 32'(bus.pac_pixel), 32'(p1_pix));
        check("anim_code", 32'(bus.anim_code), 32'(m_code));
        p1_pix = exp_pix;
    endtask

    // One short video frame: VS low for 2 cycles (tick on the first), optional scan near the sprite.
    task automatic frame(input int len, input bit scan);
        for (int i = 0; i < len; i++) begin
            bus.VGA_VS = (i < 2) ? 1'b0 : 1'b1;
            if (scan) begin
                bus.DrawX = 10'(int'(bus.pac_x) + int'($urandom_range(0, 18)) - 3);
                bus.DrawY = 10'(int'(bus.pac_y) + int'($urandom_range(0, 18)) - 3);
            end
            cycle();
        end
    endtask

    int exp2[4] = '{3, 4, 3, 0};
    int exp6;

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = (i < 117) ? 13'($urandom) : '0;
        bus.VGA_VS = 1'b1; bus.DrawX = '0; bus.DrawY = '0;
        bus.pac_x = 10'd100; bus.pac_y = 10'd50; bus.pac_dir = DIR_UP; bus.pac_moving = 1'b0;
        Reset = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_addr", 32'(bus.rom_addr), 32'd0);
        check("reset_pixel", 32'(bus.pac_pixel), 32'd0);
        check("reset_code", 32'(bus.anim_code), 32'd0);
        Reset = 1'b0;

        // Animation sequence over 16 ticks, dir right.
        bus.pac_dir = DIR_RIGHT; bus.pac_moving = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            frame(6, 1'b1);
            if (t % 4 == 0) check("anim_seq", 32'(bus.anim_code), 32'(exp2[t / 4 - 1]));
        end

        // Row scan across the sprite with code 0.
        bus.VGA_VS = 1'b1; bus.DrawY = 10'd56;
        for (int x = 98; x <= 114; x++) begin
            bus.DrawX = 10'(x);
            cycle();
        end
        bus.DrawX = '0;
        repeat (2) cycle();

        // Sprite straddling the right edge.
        bus.pac_x = 10'd630; bus.pac_y = 10'd200; bus.DrawY = 10'd205;
        for (int x = 625; x <= 639; x++) begin
            bus.DrawX = 10'(x);
            cycle();
        end
        for (int x = 0; x <= 5; x++) begin
            bus.DrawX = 10'(x);
            cycle();
        end

        // Reach FULL with dir right, then change direction mid-frame.
        bus.pac_x = 10'd100; bus.pac_y = 10'd50;
        for (int k = 0; k < 40 && m_code != 4; k++) frame(6, 1'b1);
        check("reach_full", 32'(bus.anim_code), 32'd4);
        bus.VGA_VS = 1'b1; bus.pac_dir = DIR_LEFT;
        repeat (5) begin
            bus.DrawX = 10'(100 + $urandom_range(0, 12));
            cycle();
        end
        check("dir_hold", 32'(bus.anim_code), 32'd4);
        frame(6, 1'b1);
        check("dir_latch", 32'(bus.anim_code), 32'd8);

        // Stop while open.
        bus.pac_dir = DIR_RIGHT; bus.pac_moving = 1'b0;
`ifdef PAC_STOP_CLOSED_EN
        exp6 = 0;
`else
        exp6 = 4;
`endif
        repeat (8) frame(5, 1'b1);
        check("stop_code", 32'(bus.anim_code), 32'(exp6));

        // Randomized frames: direction, motion, position and frame length all vary.
        repeat (40) begin
            bus.pac_dir = 2'($urandom_range(0, 3));
            bus.pac_moving = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.pac_x = 10'($urandom_range(0, 639));
                bus.pac_y = 10'($urandom_range(0, 479));
            end
            frame(int'($urandom_range(3, 8)), 1'b1);
        end

        // Asynchronous reset mid-line while moving and hitting the sprite.
        bus.pac_x = 10'd100; bus.pac_y = 10'd50; bus.pac_dir = DIR_RIGHT; bus.pac_moving = 1'b1;
        bus.VGA_VS = 1'b1; bus.DrawX = 10'd106; bus.DrawY = 10'd56;
        repeat (3) cycle();
        #2;
        Reset = 1'b1;
        #1;
        check("async_addr", 32'(bus.rom_addr), 32'd0);
        check("async_pixel", 32'(bus.pac_pixel), 32'd0);
        check("async_code", 32'(bus.anim_code), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        repeat (4) frame(6, 1'b1);
        check("post_reset", 32'(bus.anim_code), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
